// File: rtl/uplink_pkg.sv
// Shared definitions for the AGC uplink keyer.
// Contents:
//   state_t          - serialiser FSM states
//   UPL_WORD_W       - bits per uplink word (16)
//   KEY_W            - DSKY key code width (5)
//   make_uplink_word - builds {1, k, ~k, k}, transmitted MSB first
package uplink_pkg;

  localparam int UPL_WORD_W = 16;
  localparam int KEY_W      = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PULSE = 3'd2,
    S_SPACE = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  function automatic logic [UPL_WORD_W-1:0] make_uplink_word(input logic [KEY_W-1:0] key);
    return {1'b1, key, ~key, key};
  endfunction

endpackage

// File: rtl/uplink_fifo.sv
// Small synchronous circular-buffer FIFO for queued key codes.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push, wdata   - write request and data (ignored while full)
//   pop           - read request (ignored while empty)
//   rdata         - head entry, valid whenever !empty
//   full, empty   - occupancy flags, derived from registered pointers only
module uplink_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_en;
  logic             w_pop_en;

  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_en) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop_en)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  assign rdata = r_mem[r_rptr[AW-1:0]];
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/uplink_keyer.sv
// Programmatic AGC uplink source: queues DSKY key codes and serialises each
// one as a 16-bit uplink word, one pulse per bit on upl1 (1) or upl0 (0).
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   key_valid, key_code  - key code offer; accepted when key_ready is high
//   key_ready            - FIFO not full (independent of key_valid)
//   upl0, upl1           - registered uplink pulses, never high together
//   busy                 - word in flight, gap running, or codes queued
//   overflow             - sticky: a key was offered while key_ready was low
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | nothing in flight; leave as soon as the FIFO holds a code
// S_LOAD  | pop one code, build the shift register, bit_idx = 15
// S_PULSE | drive the current MSB on upl1/upl0 for PULSE_CYCLES
// S_SPACE | both low for the rest of the bit period, then next bit
// S_GAP   | both low for WORD_GAP_CYCLES after the last bit
module uplink_keyer
  import uplink_pkg::*;
#(
  parameter int PULSE_CYCLES    = 600,
  parameter int BIT_CYCLES      = 12000,
  parameter int WORD_GAP_CYCLES = 120000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             key_ready,
  output logic             upl0,
  output logic             upl1,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_MAX_PB = (PULSE_CYCLES > BIT_CYCLES) ? PULSE_CYCLES : BIT_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_PB > WORD_GAP_CYCLES) ? CNT_MAX_PB : WORD_GAP_CYCLES;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(BIT_CYCLES - PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(WORD_GAP_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [UPL_WORD_W-1:0]   r_shreg;
  logic [UPL_WORD_W-1:0]   w_shreg_nxt;
  logic [3:0]              r_bit_idx;
  logic [3:0]              w_bit_idx_nxt;
  logic                    r_upl0;
  logic                    r_upl1;
  logic                    w_upl0_nxt;
  logic                    w_upl1_nxt;
  logic                    r_overflow;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [KEY_W-1:0]        w_fifo_rdata;

  assign key_ready = !w_full;

  uplink_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (key_valid && key_ready),
    .wdata (key_code),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_bit_idx  <= '0;
      r_upl0     <= 1'b0;
      r_upl1     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_upl0     <= w_upl0_nxt;
      r_upl1     <= w_upl1_nxt;
      r_overflow <= r_overflow | (key_valid & w_full);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_shreg_nxt   = r_shreg;
    w_bit_idx_nxt = r_bit_idx;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_pop         = 1'b1;
        w_shreg_nxt   = make_uplink_word(w_fifo_rdata);
        w_bit_idx_nxt = 4'd15;
        w_state_nxt   = S_PULSE;
      end
      S_PULSE: begin
        if (r_cnt == PULSE_LAST) w_state_nxt = S_SPACE;
      end
      S_SPACE: begin
        if (r_cnt == SPACE_LAST) begin
          if (r_bit_idx == 4'd0) begin
            w_state_nxt = S_GAP;
          end else begin
            w_shreg_nxt   = {r_shreg[UPL_WORD_W-2:0], 1'b0};
            w_bit_idx_nxt = r_bit_idx - 4'd1;
            w_state_nxt   = S_PULSE;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Every state change restarts the shared counter.
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    // Outputs are registered from next-state values so each pulse starts on
    // the same edge that enters S_PULSE and ends on the edge that leaves it.
    w_upl1_nxt = (w_state_nxt == S_PULSE) &&  w_shreg_nxt[UPL_WORD_W-1];
    w_upl0_nxt = (w_state_nxt == S_PULSE) && !w_shreg_nxt[UPL_WORD_W-1];
  end

  assign upl0     = r_upl0;
  assign upl1     = r_upl1;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uplink_keyer.sv
// Self-checking bench for uplink_keyer with shortened timing parameters.
module tb_uplink_keyer;
  import uplink_pkg::*;

  localparam int P = 3;
  localparam int B = 8;
  localparam int G = 20;
  localparam int D = 4;
  localparam int WORD_CYC = 16 * B + G + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       key_ready, upl0, upl1, busy, overflow;

  uplink_keyer #(
    .PULSE_CYCLES    (P),
    .BIT_CYCLES      (B),
    .WORD_GAP_CYCLES (G),
    .FIFO_DEPTH      (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .upl0      (upl0),
    .upl1      (upl1),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  int          word_starts[$];
  int          pulses = 0;
  int          words_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: decodes pulses into words and compares against the scoreboard.
  logic        m_prev = 1'b0;
  int          m_bits = 0;
  int          m_hi = 0;
  int          m_last_rise = 0;
  logic [15:0] m_acc = '0;
  bit          m_in_pulse = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_bits = 0;
      m_in_pulse = 0;
      m_prev = 1'b0;
    end else begin
      if ((upl0 || upl1) && !m_prev) begin
        if (m_bits == 0) word_starts.push_back(cyc);
        else chk("bit_period", cyc - m_last_rise, B);
        m_last_rise = cyc;
        m_hi = 1;
        m_in_pulse = 1;
        m_acc = {m_acc[14:0], upl1};
        m_bits++;
        pulses++;
      end else if (upl0 || upl1) begin
        m_hi++;
      end else if (m_in_pulse) begin
        m_in_pulse = 0;
        chk("pulse_width", m_hi, P);
        if (m_bits == 16) begin
          m_bits = 0;
          words_seen++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL word_unexpected actual=%0h required=none", m_acc);
          end else begin
            chk("word", m_acc, exp_q.pop_front());
          end
        end
      end
      m_prev = upl0 || upl1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      a_excl: assert (!(upl0 && upl1)) else begin
        bad++;
        $display("FAIL exclusive actual=upl0:%b,upl1:%b required=not both", upl0, upl1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    word_starts.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_start(input int n, input int budget);
    int k = 0;
    while (word_starts.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("word_start_seen", word_starts.size() >= n, 1);
  endtask

  task automatic push_now(input logic [4:0] k, input logic [15:0] w);
    key_valid = 1'b1;
    key_code = k;
    exp_q.push_back(w);
    tick();
  endtask

  logic [4:0]  k0, k1;
  logic [15:0] b2b_words[3] = '{16'hC1F0, 16'h87C1, 16'hFC1F};
  logic [4:0]  b2b_keys[3] = '{5'h10, 5'h01, 5'h1F};
  int          acc_cyc, w0, s0, p0, n;

  initial begin
    // Reset state
    do_reset();
    chk("rst_upl0", upl0, 0);
    chk("rst_upl1", upl1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready", key_ready, 1);
    chk("pkg_word_1c", make_uplink_word(5'b11100), 16'hF07C);

    // Single key 0x1C
    acc_cyc = cyc + 1;
    push_now(5'b11100, 16'hF07C);
    key_valid = 1'b0;
    chk("single_busy", busy, 1);
    wait_start(1, 10);
    chk("first_rise_latency", word_starts[0] - acc_cyc, 2);
    wait_idle("single", WORD_CYC + 20);
    chk("single_pulses", pulses, 16);
    chk("single_q_empty", exp_q.size(), 0);

    // Back-to-back 0x10, 0x01, 0x1F
    word_starts.delete();
    acc_cyc = cyc + 1;
    for (int i = 0; i < 3; i++) push_now(b2b_keys[i], b2b_words[i]);
    key_valid = 1'b0;
    n = 0;
    while (busy && n < 4 * WORD_CYC) begin
      tick();
      n++;
    end
    chk("b2b_idle", busy, 0);
    chk("b2b_words", word_starts.size(), 3);
    if (word_starts.size() == 3) begin
      chk("b2b_first_latency", word_starts[0] - acc_cyc, 2);
      chk("b2b_spacing_01", word_starts[1] - word_starts[0], WORD_CYC);
      chk("b2b_spacing_12", word_starts[2] - word_starts[1], WORD_CYC);
      chk("b2b_busy_fall", cyc - word_starts[2], 16 * B + G);
    end
    chk("b2b_q_empty", exp_q.size(), 0);

    // FIFO full / overflow
    do_reset();
    w0 = words_seen;
    push_now(5'h0A, make_uplink_word(5'h0A));
    key_valid = 1'b0;
    wait_start(1, 10);
    for (int i = 0; i < 8; i++) begin
      key_valid = 1'b1;
      key_code = 5'(i + 2);
      chk("ovf_ready", key_ready, (i < 4) ? 1 : 0);
      if (i < 4) exp_q.push_back(make_uplink_word(5'(i + 2)));
      tick();
    end
    key_valid = 1'b0;
    chk("ovf_ready_low", key_ready, 0);
    chk("ovf_flag", overflow, 1);
    wait_idle("ovf", 6 * WORD_CYC);
    chk("ovf_word_count", words_seen - w0, 5);
    chk("ovf_q_empty", exp_q.size(), 0);

    // Push offered on the pop edge while full
    do_reset();
    w0 = words_seen;
    push_now(5'h15, make_uplink_word(5'h15));
    key_valid = 1'b0;
    wait_start(1, 10);
    for (int i = 0; i < 4; i++) push_now(5'(5'h16 + i), make_uplink_word(5'(5'h16 + i)));
    key_valid = 1'b0;
    chk("pp_full_ready", key_ready, 0);
    chk("pp_no_overflow_yet", overflow, 0);
    s0 = word_starts[0];
    n = 0;
    while (cyc < s0 + 16 * B + G + 1 && n < 2 * WORD_CYC) begin
      tick();
      n++;
    end
    chk("pp_at_load_ready", key_ready, 0);
    key_valid = 1'b1;
    key_code = 5'h1A;
    tick();
    chk("pp_overflow_set", overflow, 1);
    chk("pp_ready_after_pop", key_ready, 1);
    exp_q.push_back(make_uplink_word(5'h1A));
    tick();
    key_valid = 1'b0;
    chk("pp_ready_refull", key_ready, 0);
    wait_idle("pp", 7 * WORD_CYC);
    chk("pp_word_count", words_seen - w0, 6);
    chk("pp_q_empty", exp_q.size(), 0);

    // Reset during the pulse of bit 7
    do_reset();
    push_now(5'h07, make_uplink_word(5'h07));
    push_now(5'h0C, make_uplink_word(5'h0C));
    key_valid = 1'b0;
    n = 0;
    while (m_bits != 9 && n < WORD_CYC) begin
      tick();
      n++;
    end
    chk("mid_reached_bit7", m_bits, 9);
    chk("mid_pulse_high", upl0 || upl1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_upl0", upl0, 0);
    chk("mid_rst_upl1", upl1, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", key_ready, 1);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    p0 = pulses;
    repeat (2 * WORD_CYC) tick();
    chk("mid_no_pulses", pulses - p0, 0);
    chk("mid_busy_idle", busy, 0);
    chk("mid_overflow_clear", overflow, 0);

    // Random keys in pairs
    for (int p = 0; p < 25; p++) begin
      k0 = 5'($urandom_range(0, 31));
      k1 = 5'($urandom_range(0, 31));
      chk("rnd_ready", key_ready, 1);
      push_now(k0, make_uplink_word(k0));
      push_now(k1, make_uplink_word(k1));
      key_valid = 1'b0;
      wait_idle("rnd", 2 * WORD_CYC + 20);
    end
    chk("rnd_q_empty", exp_q.size(), 0);
    chk("rnd_no_overflow", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
